// File: rtl/pacman_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pacman_vga_pkg
// Purpose : Shared types, requester indices and helpers for the plot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package pacman_vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAP    = 2'd1,
        ST_SPRITE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int X_W_DEFAULT = 8;
    localparam int Y_W_DEFAULT = 7;
    localparam int C_W_DEFAULT = 3;

    localparam logic [1:0] REQ_MAP  = 2'd0;
    localparam logic [1:0] REQ_SPR1 = 2'd1;
    localparam logic [1:0] REQ_SPR2 = 2'd2;
    localparam logic [1:0] REQ_SPR3 = 2'd3;

    // Sprite index -> its bit in the 3-bit done mask (bit 0 = sprite 1).
    function automatic logic [2:0] spr_bit(input logic [1:0] idx);
        case (idx)
            REQ_SPR1: spr_bit = 3'b001;
            REQ_SPR2: spr_bit = 3'b010;
            REQ_SPR3: spr_bit = 3'b100;
            default:  spr_bit = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] spr_succ(input logic [1:0] idx);
        case (idx)
            REQ_SPR1: spr_succ = REQ_SPR2;
            REQ_SPR2: spr_succ = REQ_SPR3;
            default:  spr_succ = REQ_SPR1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next.sv
`default_nettype none
// ============================================================================
// Module  : rr_next
// Purpose : Next not-done sprite after the current owner, cyclic 1->2->3->1.
// Revision: 1.0 - initial release
// ============================================================================
module rr_next
    import pacman_vga_pkg::*;
(
    input  logic [1:0] owner_i,
    input  logic [2:0] done_mask_i,
    output logic [1:0] next_o
);

    logic [1:0] w_c1;
    logic [1:0] w_c2;

    assign w_c1 = spr_succ(owner_i);
    assign w_c2 = spr_succ(w_c1);

    // Falls back to the owner itself when it is the only candidate left.
    always_comb begin
        next_o = owner_i;
        if (~|(done_mask_i & spr_bit(w_c1))) begin
            next_o = w_c1;
        end else if (~|(done_mask_i & spr_bit(w_c2))) begin
            next_o = w_c2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_plot_arbiter
// Purpose : Arbitrates map and sprite pixel streams onto one VGA plot port.
// Revision: 1.0 - initial release
// ============================================================================
module vga_plot_arbiter
    import pacman_vga_pkg::*;
#(
    parameter int BURST_MAX = 16,
    parameter int X_W       = X_W_DEFAULT,
    parameter int Y_W       = Y_W_DEFAULT,
    parameter int C_W       = C_W_DEFAULT
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [2:0]       sprite_en,
    input  logic [3:0]       req,
    input  logic [3:0]       req_last,
    input  logic [4*X_W-1:0] req_x,
    input  logic [4*Y_W-1:0] req_y,
    input  logic [4*C_W-1:0] req_color,
    output logic [3:0]       grant,
    output logic             vga_plot,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [C_W-1:0]   vga_color,
    output logic             busy,
    output logic             frame_done
);

    localparam int              BW           = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]   C_BURST_LAST = BW'(BURST_MAX - 1);

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [2:0]      mask_q, mask_d;
    logic            plot_q;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [C_W-1:0]  color_q;

    logic [2:0]      w_own_bit;
    logic [1:0]      w_idx;
    logic [1:0]      w_next;
    logic            w_xfer;
    logic            w_last;

    assign w_own_bit = spr_bit(owner_q);

    // Grant and done-mask update; kept apart from the FSM so rr_next sees
    // the post-transfer mask without forming a combinational loop.
    always_comb begin
        grant  = 4'b0000;
        w_idx  = REQ_MAP;
        mask_d = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    mask_d = ~sprite_en;
                end
            end
            ST_MAP: begin
                grant = {3'b000, req[REQ_MAP]};
            end
            ST_SPRITE: begin
                w_idx = owner_q;
                if (~|(mask_q & w_own_bit) && req[owner_q]) begin
                    grant = {w_own_bit, 1'b0};
                    if (req_last[owner_q]) begin
                        mask_d = mask_q | w_own_bit;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_xfer = |(req & grant);
    assign w_last = |(req & req_last & grant);

    rr_next u_rr_next (
        .owner_i     (owner_q),
        .done_mask_i (mask_d),
        .next_o      (w_next)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_MAP;
                    owner_d = REQ_SPR1;
                    burst_d = '0;
                end
            end
            ST_MAP: begin
                if (w_last) begin
                    state_d = ST_SPRITE;
                end
            end
            ST_SPRITE: begin
                if (mask_q == 3'b111) begin
                    state_d = ST_DONE;
                end else if (!w_xfer || w_last || (burst_q == C_BURST_LAST)) begin
                    owner_d = w_next;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + BW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_SPR1;
            burst_q <= '0;
            mask_q  <= 3'b000;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            mask_q  <= mask_d;
            plot_q  <= w_xfer;
            if (w_xfer) begin
                x_q     <= req_x[w_idx*X_W +: X_W];
                y_q     <= req_y[w_idx*Y_W +: Y_W];
                color_q <= req_color[w_idx*C_W +: C_W];
            end
        end
    end

    assign vga_plot   = plot_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_color  = color_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

endmodule
`default_nettype wire
